spi_read_logger: RTL and testbench
==================================

SPI_READ_LOGGER -- requirements
Module: spi_read_logger

Interface
REQ-001 The module SHALL have parameter FAST_READ_EN, default 1, which when 1 decodes opcode 0x0B (fast read) in addition to 0x03 (read).
REQ-002 The module SHALL have parameter CS_SYNC_STAGES, default 3, giving the number of flops in the CS synchroniser (minimum 2).
REQ-003 mclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-005 spi_cs  input  1  raw, unsynchronised bus chip-select; idles high; active low.
REQ-006 spi_rx_strobe  input  1  single-cycle pulse from the SPI byte receiver, synchronous to mclk.
REQ-007 spi_rx_data  input  8  received MOSI byte, valid while spi_rx_strobe=1.
REQ-008 log_data  output  16  two ASCII characters for the 16-to-8 log FIFO; bits [15:8] are sent first.
REQ-009 log_strobe  output  1  single-cycle write pulse qualifying log_data.
REQ-010 read_addr  output  24  current emulated-flash byte address.
REQ-011 read_active  output  1  high while a decoded read command is in ADDR, DUMMY or DATA.
REQ-012 data_bytes  output  16  number of data-phase bytes in the current or last read; saturates at 0xFFFF.

Function
REQ-013 spi_cs SHALL pass through CS_SYNC_STAGES flops; cs_s is the last stage and cs_p is the stage before it.
REQ-014 A falling edge is cs_p=0 and cs_s=1; a rising edge is cs_p=1 and cs_s=0. Edges SHALL be acted on in the cycle they are detected.
REQ-015 The FSM states SHALL be IDLE, CMD, ADDR, DUMMY, DATA and IGNORE.
REQ-016 IDLE SHALL move to CMD on a falling edge; spi_rx_strobe SHALL be ignored in IDLE.
REQ-017 In CMD, a strobe with byte 0x03 SHALL go to ADDR. A strobe with 0x0B and FAST_READ_EN=1 SHALL go to ADDR. Any other byte SHALL go to IGNORE.
REQ-018 Entering ADDR SHALL clear an internal 2-bit address-byte counter and data_bytes.
REQ-019 In ADDR, each strobe SHALL set read_addr <= {read_addr[15:0], spi_rx_data}. The block SHALL pulse log_strobe with log_data = {hex(byte[7:4]), hex(byte[3:0])}.
REQ-020 hex(n) SHALL be ASCII uppercase: 0x30+n for n<10 and 0x37+n for n>=10.
REQ-021 After the third address strobe, the FSM SHALL go to DUMMY if the opcode was 0x0B, otherwise to DATA.
REQ-022 DUMMY SHALL consume exactly one strobe, leave read_addr unchanged, and then go to DATA.
REQ-023 In DATA, each strobe SHALL increment read_addr modulo 2^24 (0xFFFFFF wraps to 0x000000) and increment data_bytes, saturating at 0xFFFF.
REQ-024 IGNORE SHALL discard all strobes.
REQ-025 A rising edge SHALL return any state to IDLE.
REQ-026 If the state at a rising edge is ADDR, DUMMY or DATA, log_strobe SHALL pulse with log_data = 0x0D0A ("\r\n").
REQ-027 A falling edge seen in any state other than IDLE SHALL restart at CMD with no newline (glitch or missed edge).
REQ-028 When a CS edge and spi_rx_strobe occur in the same cycle, the edge SHALL take priority and the strobe SHALL be dropped.
REQ-029 At most one log_strobe SHALL occur per cycle; log_strobe SHALL never be asserted on consecutive cycles.
REQ-030 log_strobe, log_data, read_addr, read_active and data_bytes SHALL be registered outputs.
REQ-031 Latency SHALL be one mclk from the spi_rx_strobe (or edge-detect) cycle to the log_strobe and read_addr update.
REQ-032 read_active SHALL be 1 exactly while the state is ADDR, DUMMY or DATA, and update with the state.

Reset
REQ-033 While reset=0: state SHALL be IDLE, all synchroniser flops 1, log_strobe 0, log_data 0x0000, read_addr 0x000000, read_active 0, data_bytes 0.
REQ-034 Reset asserted mid-transaction SHALL abort with no newline emitted.
REQ-035 After reset releases with spi_cs low, no falling edge SHALL be detected until spi_cs goes high and then low again.

Verification
REQ-036 CS low; bytes 03,12,AB,CD,then 4 data bytes; CS high -> log words 0x3132, 0x4142, 0x4344, then 0x0D0A; read_addr=0x12ABD1; data_bytes=4.
REQ-037 FAST_READ_EN=1; bytes 0B,FF,FF,FF,00 (dummy) + 2 data -> log words 0x4646 x3, then 0x0D0A; read_addr wraps to 0x000001; data_bytes=2.
REQ-038 CS low; bytes 9F,00,00; CS high -> no log_strobe; read_active stays 0. With FAST_READ_EN=0, opcode 0B gives the same result.
REQ-039 CS rises in the same cycle as the third address strobe -> that byte is dropped, exactly one 0x0D0A is logged, and the FSM returns to IDLE.
REQ-040 reset=0 asserted during DATA -> all outputs zero immediately and no newline. The next full read from CS high then low logs correctly.
REQ-041 200 data bytes at back-to-back strobes every 2 mclk -> data_bytes=200 and no log_strobe during DATA.

Source files
------------

// File: rtl/spi_read_logger.sv
// SPI flash read-command logger: decodes READ/FAST_READ transactions, emits the
// address bytes as ASCII hex to a log FIFO and tracks the emulated read address.
module spi_read_logger #(
   parameter int unsigned FAST_READ_EN   = 1,
   parameter int unsigned CS_SYNC_STAGES = 3
) (
   input  logic        mclk,
   input  logic        reset,
   input  logic        spi_cs,
   input  logic        spi_rx_strobe,
   input  logic [7:0]  spi_rx_data,
   output logic [15:0] log_data,
   output logic        log_strobe,
   output logic [23:0] read_addr,
   output logic        read_active,
   output logic [15:0] data_bytes
);

   localparam int unsigned SYNC_N = (CS_SYNC_STAGES < 2) ? 2 : CS_SYNC_STAGES;

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

   function automatic logic [7:0] hex(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

   state_t      state, state_n;
   logic [SYNC_N-1:0] cs_sync, sync_vld;
   logic        cs_s, cs_p, live, cs_fall, cs_rise, in_read;
   logic        fast, fast_n;
   logic [1:0]  addr_cnt, addr_cnt_n;
   logic        crlf_pend, crlf_pend_n;
   logic [23:0] read_addr_n;
   logic [15:0] data_bytes_n, log_data_n;
   logic        log_strobe_n;

   // sync_vld keeps reset-preset synchroniser ones from posing as a real
   // "CS high" sample, so CS held low across reset release is not an edge.
   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         cs_sync  <= '1;
         sync_vld <= '0;
      end else begin
         cs_sync  <= {cs_sync[SYNC_N-2:0], spi_cs};
         sync_vld <= {sync_vld[SYNC_N-2:0], 1'b1};
      end
   end

   assign cs_s    = cs_sync[SYNC_N-1];
   assign cs_p    = cs_sync[SYNC_N-2];
   assign live    = sync_vld[SYNC_N-1];
   assign cs_fall = live & ~cs_p & cs_s;
   assign cs_rise = live & cs_p & ~cs_s;
   assign in_read = (state == ADDR) || (state == DUMMY) || (state == DATA);

   always_comb begin
      state_n      = state;
      fast_n       = fast;
      addr_cnt_n   = addr_cnt;
      crlf_pend_n  = crlf_pend;
      read_addr_n  = read_addr;
      data_bytes_n = data_bytes;
      log_data_n   = log_data;
      log_strobe_n = 1'b0;

      // A newline that would have followed a log pulse directly is held one cycle.
      if (crlf_pend && !log_strobe) begin
         crlf_pend_n  = 1'b0;
         log_strobe_n = 1'b1;
         log_data_n   = 16'h0D0A;
      end

      if (cs_rise) begin
         state_n = IDLE;
         if (in_read) begin
            if (log_strobe) begin
               crlf_pend_n = 1'b1;
            end else begin
               log_strobe_n = 1'b1;
               log_data_n   = 16'h0D0A;
            end
         end
      end else if (cs_fall) begin
         state_n = CMD;
      end else if (spi_rx_strobe) begin
         unique case (state)
            CMD: begin
               if (spi_rx_data == 8'h03 ||
                   (spi_rx_data == 8'h0B && FAST_READ_EN != 0)) begin
                  state_n      = ADDR;
                  fast_n       = (spi_rx_data == 8'h0B);
                  addr_cnt_n   = '0;
                  data_bytes_n = '0;
               end else begin
                  state_n = IGNORE;
               end
            end
            ADDR: begin
               read_addr_n  = {read_addr[15:0], spi_rx_data};
               log_strobe_n = 1'b1;
               log_data_n   = {hex(spi_rx_data[7:4]), hex(spi_rx_data[3:0])};
               addr_cnt_n   = addr_cnt + 2'd1;
               if (addr_cnt == 2'd2) state_n = fast ? DUMMY : DATA;
            end
            DUMMY: state_n = DATA;
            DATA: begin
               read_addr_n = read_addr + 24'd1;
               if (data_bytes != 16'hFFFF) data_bytes_n = data_bytes + 16'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         fast        <= 1'b0;
         addr_cnt    <= '0;
         crlf_pend   <= 1'b0;
         read_addr   <= '0;
         data_bytes  <= '0;
         log_data    <= '0;
         log_strobe  <= 1'b0;
         read_active <= 1'b0;
      end else begin
         state       <= state_n;
         fast        <= fast_n;
         addr_cnt    <= addr_cnt_n;
         crlf_pend   <= crlf_pend_n;
         read_addr   <= read_addr_n;
         data_bytes  <= data_bytes_n;
         log_data    <= log_data_n;
         log_strobe  <= log_strobe_n;
         read_active <= (state_n == ADDR) || (state_n == DUMMY) || (state_n == DATA);
      end
   end

endmodule

// File: tb/tb_spi_read_logger.sv
// Directed bench for spi_read_logger; a second instance with fast read disabled
// shares the stimulus.
module tb_spi_read_logger;

   logic        mclk = 1'b0;
   logic        reset = 1'b0;
   logic        spi_cs = 1'b1;
   logic        spi_rx_strobe = 1'b0;
   logic [7:0]  spi_rx_data = 8'h00;
   logic [15:0] log_data, nf_log_data;
   logic        log_strobe, nf_log_strobe;
   logic [23:0] read_addr, nf_read_addr;
   logic        read_active, nf_read_active;
   logic [15:0] data_bytes, nf_data_bytes;

   int checks = 0;
   int passed = 0;

   logic [15:0] log_q[$];
   int consec = 0, nf_logs = 0, nf_active = 0, active_cycles = 0;
   logic prev_strobe = 1'b0;
   int base, a0, n0, na0;

   always #5 mclk = ~mclk;

   spi_read_logger dut (
      .mclk(mclk), .reset(reset), .spi_cs(spi_cs), .spi_rx_strobe(spi_rx_strobe),
      .spi_rx_data(spi_rx_data), .log_data(log_data), .log_strobe(log_strobe),
      .read_addr(read_addr), .read_active(read_active), .data_bytes(data_bytes)
   );

   spi_read_logger #(.FAST_READ_EN(0)) dut_nf (
      .mclk(mclk), .reset(reset), .spi_cs(spi_cs), .spi_rx_strobe(spi_rx_strobe),
      .spi_rx_data(spi_rx_data), .log_data(nf_log_data), .log_strobe(nf_log_strobe),
      .read_addr(nf_read_addr), .read_active(nf_read_active), .data_bytes(nf_data_bytes)
   );

   always @(negedge mclk) begin
      if (log_strobe) begin
         log_q.push_back(log_data);
         if (prev_strobe) consec++;
      end
      prev_strobe = log_strobe;
      if (nf_log_strobe) nf_logs++;
      if (nf_read_active) nf_active++;
      if (read_active) active_cycles++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      spi_rx_data   = b;
      spi_rx_strobe = 1'b1;
      step();
      spi_rx_strobe = 1'b0;
      step();
   endtask

   task automatic cs_low();
      spi_cs = 1'b0;
      repeat (4) step();
   endtask

   task automatic cs_high();
      spi_cs = 1'b1;
      repeat (5) step();
   endtask

   initial begin
      // reset state
      repeat (2) step();
      chk("rst_log_strobe", log_strobe, 0);
      chk("rst_log_data", log_data, 16'h0000);
      chk("rst_read_addr", read_addr, 24'h000000);
      chk("rst_read_active", read_active, 0);
      chk("rst_data_bytes", data_bytes, 0);
      reset = 1'b1;
      repeat (5) step();

      // plain read: 03 12 AB CD + 4 data
      base = log_q.size();
      cs_low();
      send_byte(8'h03);
      send_byte(8'h12); send_byte(8'hAB); send_byte(8'hCD);
      chk("t1_addr", read_addr, 24'h12ABCD);
      chk("t1_active", read_active, 1);
      send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      cs_high();
      chk("t1_nlogs", log_q.size() - base, 4);
      chk("t1_log0", log_q[base], 16'h3132);
      chk("t1_log1", log_q[base+1], 16'h4142);
      chk("t1_log2", log_q[base+2], 16'h4344);
      chk("t1_log3", log_q[base+3], 16'h0D0A);
      chk("t1_read_addr", read_addr, 24'h12ABD1);
      chk("t1_data_bytes", data_bytes, 4);
      chk("t1_idle_active", read_active, 0);

      // fast read with address wrap; non-fast instance must ignore it
      base = log_q.size(); n0 = nf_logs; na0 = nf_active;
      cs_low();
      send_byte(8'h0B);
      send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
      chk("t2_addr", read_addr, 24'hFFFFFF);
      chk("t2_db_cleared", data_bytes, 0);
      send_byte(8'h00);
      chk("t2_dummy_addr", read_addr, 24'hFFFFFF);
      chk("t2_dummy_db", data_bytes, 0);
      send_byte(8'h55); send_byte(8'hAA);
      cs_high();
      chk("t2_nlogs", log_q.size() - base, 4);
      chk("t2_log0", log_q[base], 16'h4646);
      chk("t2_log1", log_q[base+1], 16'h4646);
      chk("t2_log2", log_q[base+2], 16'h4646);
      chk("t2_log3", log_q[base+3], 16'h0D0A);
      chk("t2_read_addr", read_addr, 24'h000001);
      chk("t2_data_bytes", data_bytes, 2);
      chk("t2_nf_logs", nf_logs - n0, 0);
      chk("t2_nf_active", nf_active - na0, 0);

      // unsupported opcode
      base = log_q.size(); a0 = active_cycles;
      cs_low();
      send_byte(8'h9F); send_byte(8'h00); send_byte(8'h00);
      cs_high();
      chk("t3_nlogs", log_q.size() - base, 0);
      chk("t3_active", active_cycles - a0, 0);
      chk("t3_read_addr", read_addr, 24'h000001);

      // CS rises in the same cycle as the third address strobe
      base = log_q.size();
      cs_low();
      send_byte(8'h03);
      send_byte(8'h01); send_byte(8'h02);
      spi_cs = 1'b1;
      step(); step();
      spi_rx_data = 8'h03; spi_rx_strobe = 1'b1;
      step();
      spi_rx_strobe = 1'b0;
      repeat (3) step();
      chk("t4_nlogs", log_q.size() - base, 3);
      chk("t4_log0", log_q[base], 16'h3031);
      chk("t4_log1", log_q[base+1], 16'h3032);
      chk("t4_log2", log_q[base+2], 16'h0D0A);
      chk("t4_read_addr", read_addr, 24'h010102);
      chk("t4_active", read_active, 0);

      // reset during DATA, released with CS still low
      base = log_q.size();
      cs_low();
      send_byte(8'h03);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
      send_byte(8'h77); send_byte(8'h88);
      chk("t5_pre_addr", read_addr, 24'h000012);
      chk("t5_pre_db", data_bytes, 2);
      reset = 1'b0;
      #1;
      chk("t5_rst_addr", read_addr, 24'h000000);
      chk("t5_rst_db", data_bytes, 0);
      chk("t5_rst_active", read_active, 0);
      chk("t5_rst_log_data", log_data, 16'h0000);
      chk("t5_rst_log_strobe", log_strobe, 0);
      repeat (2) step();
      reset = 1'b1;
      repeat (6) step();
      a0 = active_cycles;
      send_byte(8'h03); send_byte(8'h00);
      chk("t5_no_fall", active_cycles - a0, 0);
      cs_high();
      chk("t5_no_newline", log_q.size() - base, 3);
      base = log_q.size();
      cs_low();
      send_byte(8'h03);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
      send_byte(8'h99);
      cs_high();
      chk("t5_nlogs", log_q.size() - base, 4);
      chk("t5_log2", log_q[base+2], 16'h3035);
      chk("t5_log3", log_q[base+3], 16'h0D0A);
      chk("t5_read_addr", read_addr, 24'h000006);
      chk("t5_data_bytes", data_bytes, 1);

      // 200 back-to-back data bytes
      base = log_q.size();
      cs_low();
      send_byte(8'h03);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      for (int i = 0; i < 200; i++) send_byte(8'(i));
      chk("t6_no_data_logs", log_q.size() - base, 3);
      chk("t6_data_bytes", data_bytes, 200);
      chk("t6_read_addr", read_addr, 24'h0000C8);
      cs_high();
      chk("t6_newline", log_q[base+3], 16'h0D0A);

      chk("no_consecutive_strobes", consec, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
